// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: op codes, FSM states and the
// effective shift-count helper.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (rotate op codes 100/101).
package shift_pkg;

  localparam logic [2:0] OP_LSR = 3'b000;
  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ASL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True for op codes the sequencer can execute in this build.
  function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_SEQ_ROTATE_EN
    return (op <= OP_ROL);
`else
    return (op <= OP_ASL);
`endif
  endfunction

  // Number of single-position steps needed: rotates wrap modulo the width,
  // shifts saturate at the width (which already yields the fully shifted value).
  function automatic int unsigned eff_count(input logic [2:0] op,
                                            input int unsigned amt,
                                            input int unsigned width);
    if (op == OP_ROR || op == OP_ROL)
      return amt % width;
    return (amt > width) ? width : amt;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-position shift/rotate datapath, purely combinational.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (adds rotate right/left).
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  // One step of the selected operation; unsupported codes produce zero.
  always_comb begin
    result = '0;
    case (op)
      OP_LSR:          result = {1'b0, value[WIDTH-1:1]};
      OP_LSL, OP_ASL:  result = {value[WIDTH-2:0], 1'b0};
      OP_ASR:          result = {value[WIDTH-1], value[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR:          result = {value[0], value[WIDTH-1:1]};
      OP_ROL:          result = {value[WIDTH-2:0], value[WIDTH-1]};
`endif
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable-amount shift/rotate controller. Accepts one request,
// steps a one-position shifter count times, then presents the result.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (rotate op codes 100/101).
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] work;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] eff;
  logic [WIDTH-1:0] stepped;
  logic             legal;
  logic             last_step;

  assign legal     = op_legal(in_op);
  assign eff       = CNT_W'(eff_count(in_op, 32'(in_amt), WIDTH));
  assign last_step = (cnt == CNT_W'(1));

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value  (work),
    .op     (op_q),
    .result (stepped)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode: zero-count and illegal requests skip RUN entirely.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (!legal || eff == '0) next_state = S_DONE;
          else                     next_state = S_RUN;
        end
      end
      S_RUN:   if (last_step) next_state = S_DONE;
      S_DONE:  if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: out_data is a separate register so it only moves when DONE is
  // entered, while the working register steps freely during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      op_q     <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work <= in_data;
            op_q <= in_op;
            cnt  <= legal ? eff : '0;
            if (!legal)          out_data <= '0;
            else if (eff == '0)  out_data <= in_data;
          end
        end
        S_RUN: begin
          work <= stepped;
          cnt  <= cnt - CNT_W'(1);
          if (last_step) out_data <= stepped;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed, table-driven bench for shift_sequencer with hand-written
// sequences for the DONE back-pressure and mid-RUN reset cases.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (selects rotate expectations).
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_op;
  logic [4:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  logic [7:0] last_out = 8'h00;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .AMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [2:0] op;
    logic [4:0] amt;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request with out_ready high; latency counts the accept edge as 1.
  task automatic run_op(input string name, input logic [7:0] d, input logic [2:0] op,
                        input logic [4:0] amt, input logic [7:0] exp, input int lat_exp);
    int lat;
    @(negedge clk);
    chk({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_op     = op;
    in_amt    = amt;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    lat = 1;
    chk({name, " busy"}, {31'd0, busy}, 32'd1);
    while (!out_valid && lat < 40) begin
      chk({name, " out_data hold"}, {24'd0, out_data}, {24'd0, last_out});
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, lat, lat_exp);
    chk({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, " out_data"}, {24'd0, out_data}, {24'd0, exp});
    last_out = exp;
    @(posedge clk); #1;
    chk({name, " back to idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b1;

    vecs.push_back('{"lsr_b4_3",   8'hB4, 3'b000, 5'd3,  8'h16, 4});
    vecs.push_back('{"asr_b4_3",   8'hB4, 3'b010, 5'd3,  8'hF6, 4});
    vecs.push_back('{"lsl_ff_20",  8'hFF, 3'b001, 5'd20, 8'h00, 9});
    vecs.push_back('{"ill_110",    8'h5A, 3'b110, 5'd2,  8'h00, 1});
    vecs.push_back('{"ill_111",    8'hC3, 3'b111, 5'd0,  8'h00, 1});
    vecs.push_back('{"lsr_amt0",   8'h5A, 3'b000, 5'd0,  8'h5A, 1});
    vecs.push_back('{"asr_80_31",  8'h80, 3'b010, 5'd31, 8'hFF, 9});
    vecs.push_back('{"asl_81_1",   8'h81, 3'b011, 5'd1,  8'h02, 2});
    vecs.push_back('{"lsr_81_8",   8'h81, 3'b000, 5'd8,  8'h00, 9});
    vecs.push_back('{"asr_74_2",   8'h74, 3'b010, 5'd2,  8'h1D, 3});
`ifdef SHIFT_SEQ_ROTATE_EN
    vecs.push_back('{"rol_b4_3",   8'hB4, 3'b101, 5'd3,  8'hA5, 4});
    vecs.push_back('{"ror_b4_11",  8'hB4, 3'b100, 5'd11, 8'h96, 4});
    vecs.push_back('{"ror_b4_8",   8'hB4, 3'b100, 5'd8,  8'hB4, 1});
    vecs.push_back('{"rol_81_1",   8'h81, 3'b101, 5'd1,  8'h03, 2});
`else
    vecs.push_back('{"rol_b4_3",   8'hB4, 3'b101, 5'd3,  8'h00, 1});
    vecs.push_back('{"ror_b4_11",  8'hB4, 3'b100, 5'd11, 8'h00, 1});
    vecs.push_back('{"ror_b4_8",   8'hB4, 3'b100, 5'd8,  8'h00, 1});
    vecs.push_back('{"rol_81_1",   8'h81, 3'b101, 5'd1,  8'h00, 1});
`endif

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("reset in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data",  {24'd0, out_data},  32'd0);
    chk("reset busy",      {31'd0, busy},      32'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].data, vecs[i].op, vecs[i].amt, vecs[i].exp, vecs[i].lat);

    // Back-pressure: result held in DONE, new requests ignored.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hB4; in_op = 3'b000; in_amt = 5'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 8'h33; in_op = 3'b001; in_amt = 5'd1;  // stays valid while busy
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("hold latency", lat, 4);
    for (int c = 0; c < 5; c++) begin
      chk("hold out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold out_data",  {24'd0, out_data},  32'h16);
      chk("hold in_ready",  {31'd0, in_ready},  32'd0);
      chk("hold busy",      {31'd0, busy},      32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release in_ready",  {31'd0, in_ready},  32'd1);
    chk("release out_valid", {31'd0, out_valid}, 32'd0);
    chk("release out_data",  {24'd0, out_data},  32'h16);
    last_out = 8'h16;

    // Reset mid-RUN discards the operation.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h01; in_op = 3'b001; in_amt = 5'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid-run rst in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid-run rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid-run rst busy",      {31'd0, busy},      32'd0);
    chk("mid-run rst out_data",  {24'd0, out_data},  32'd0);
    @(negedge clk); rst = 1'b0;
    last_out = 8'h00;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("post-reset no output", {31'd0, out_valid}, 32'd0);
    end
    run_op("lsl_01_7_after_rst", 8'h01, 3'b001, 5'd7, 8'h80, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift/rotate controller that executes variable-amount shift operations on an 8-bit operand by repeatedly stepping a one-position shift datapath. It sits in front of the fixed-amount shifter datapath. Requesters issue {operand, op, amount} over a valid/ready handshake and receive the result over a second valid/ready handshake. Only one operation is in flight at a time.

## Interface
- WIDTH, 8, operand/result width
- AMT_W, 5, shift-amount width (amounts 0..31)
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, synchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- in_data  input  WIDTH  operand
- in_op  input  3  operation code
- in_amt  input  AMT_W  shift amount
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid & out_ready
- out_data  output  WIDTH  result
- busy  output  1  high in RUN or DONE

## Operation
- Op codes:
  - 000 logical right
  - 001 logical left
  - 010 arithmetic right (sign-bit fill)
  - 011 arithmetic left (identical to logical left)
  - 100 rotate right
  - 101 rotate left
  - 110/111 illegal
- FSM states IDLE, RUN, DONE. in_ready = (state==IDLE).
- IDLE, on accept:
  - Latch operand into the working register and latch the op.
  - Compute the remaining count: shifts use min(in_amt, WIDTH); rotates use in_amt mod WIDTH.
  - Count 0 → DONE with result = operand.
  - Illegal op → DONE with result = 8'h00.
  - Otherwise → RUN.
- RUN: each cycle, the working register is replaced by shift_step(reg, op) and the count decrements. When the count reaches 1, this cycle's step is the last one and the FSM moves to DONE.
- DONE: out_valid=1 and out_data = working register, both held stable until out_ready. On handshake → IDLE.
- Shift amounts ≥ WIDTH: logical and left shifts give 0; arithmetic right gives all sign bits. Clamping to WIDTH guarantees this.
- in_* are ignored outside IDLE. No accept can coincide with an output handshake.

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0, in_ready=1, count=0.
- Latency from accept edge to out_valid high = effective count + 1 cycles. Minimum 1 cycle (count 0 or illegal op); maximum WIDTH+1 cycles.
- Throughput: one operation per (latency + 1) cycles when out_ready is held high, because the return to IDLE costs one cycle.
- rst asserted in any state, including mid-RUN or mid-DONE: the next edge applies the reset values, and the in-flight operation is discarded with no output.
- out_data changes only on entry to DONE or on reset.

## Configuration
- SHIFT_SEQ_ROTATE_EN
  - Defined: op codes 100/101 perform rotates as specified.
  - Undefined: 100/101 are treated as illegal (1-cycle latency, result 8'h00), and the rotate logic is removed from shift_step.

## Structure
- Package shift_pkg holds:
  - op-code localparams: OP_LSR, OP_LSL, OP_ASR, OP_ASL, OP_ROR, OP_ROL
  - FSM state encoding: S_IDLE, S_RUN, S_DONE
  - helper function for the effective-count computation
- Sub-module shift_step: purely combinational single-position shifter (WIDTH, op → next value), instantiated once.

## Test plan
- Op 000, 8'hB4, amt 3 → out_data 8'h16, out_valid 4 cycles after accept.
- Op 010, 8'hB4, amt 3 → 8'hF6. Op 101, 8'hB4, amt 3 → 8'hA5.
- Op 100, 8'hB4, amt 11 → 8'h96 (amount reduced mod 8), 4-cycle latency. Op 001, 8'hFF, amt 20 → 8'h00, 9-cycle latency.
- Op 110, any operand → 8'h00 after 1 cycle. With SHIFT_SEQ_ROTATE_EN undefined, op 101 → 8'h00 after 1 cycle.
- Hold out_ready low 5 cycles in DONE → out_data and out_valid stable, in_ready=0 and new in_valid ignored. Raise out_ready → in_ready=1 next cycle.
- Assert rst mid-RUN (op 001, amt 7, cycle 3) → next cycle state IDLE and out_valid=0. The following request completes correctly.
